// File: rtl/jtcop_dtack_if.sv
// Bus bundle between the main CPU decoder / SDRAM arbiter and the 68000 cen/DTACKn generator.
// The slave side is the DTACK block; the master side is whatever drives the CPU bus signals.
interface jtcop_dtack_if #(
  parameter int W = 5
);
  logic [W-1:0] cen_num;
  logic [W-1:0] cen_den;
  logic         ASn;
  logic         bus_cs;
  logic         bus_ok;
  logic         bus_busy;
  logic         cpu_cen;
  logic         cpu_cenb;
  logic         DTACKn;
  logic [W-1:0] miss;

  modport master (
    output cen_num, cen_den, ASn, bus_cs, bus_ok, bus_busy,
    input  cpu_cen, cpu_cenb, DTACKn, miss
  );

  modport slave (
    input  cen_num, cen_den, ASn, bus_cs, bus_ok, bus_busy,
    output cpu_cen, cpu_cenb, DTACKn, miss
  );
endinterface

// File: rtl/jtcop_dtack.sv
// 68000 clock-enable generator with a fractional divider, and DTACKn handshake that freezes the
// CPU while an SDRAM access is pending and can repay the suppressed ticks once the stall ends.
//
//   state   | meaning
//   PH_CEN  | next emitted tick drives cpu_cen (rising CPU phase)
//   PH_CENB | next emitted tick drives cpu_cenb (falling CPU phase)
module jtcop_dtack #(
  parameter int W        = 5,
  parameter bit RECOVERY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  jtcop_dtack_if.slave  bus
);

  typedef enum logic {
    PH_CEN  = 1'b0,
    PH_CENB = 1'b1
  } phase_t;

  localparam logic [W-1:0] MISS_MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

  phase_t       phase, phase_nxt;
  logic [W-1:0] acc, acc_nxt;
  logic [W-1:0] miss_q, miss_nxt;
  logic [W:0]   sum, diff;
  logic         due, stall, rec, tick;
  logic         cs_l;
  logic         cen_q, cenb_q, cen_nxt, cenb_nxt;
  logic         dtack_q, dtack_nxt;

  // divider arithmetic is one bit wider so num+acc never wraps before the compare
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, bus.cen_num};
    diff    = sum - {1'b0, bus.cen_den};
    due     = sum >= {1'b0, bus.cen_den};
    acc_nxt = due ? diff[W-1:0] : sum[W-1:0];
  end

  // bus_ok is only trusted once the select has been seen for a full clk
  always_comb begin
    stall = bus.bus_busy | (~bus.ASn & bus.bus_cs & ~(bus.bus_ok & cs_l));
    rec   = RECOVERY && !stall && !due && (miss_q != '0) && !(cen_q || cenb_q);
    tick  = (!stall && due) || rec;
  end

  always_comb begin
    miss_nxt = miss_q;
    if (RECOVERY) begin
      if (stall && due) begin
        if (miss_q != MISS_MAX) miss_nxt = miss_q + ONE;
      end else if (rec) begin
        miss_nxt = miss_q - ONE;
      end
    end
  end

  always_comb begin
    phase_nxt = phase;
    cen_nxt   = 1'b0;
    cenb_nxt  = 1'b0;
    if (tick) begin
      case (phase)
        PH_CEN: begin
          cen_nxt   = 1'b1;
          phase_nxt = PH_CENB;
        end
        PH_CENB: begin
          cenb_nxt  = 1'b1;
          phase_nxt = PH_CEN;
        end
        default: phase_nxt = PH_CEN;
      endcase
    end
  end

  // ASn high always releases DTACKn; otherwise it latches low after a clean falling phase
  always_comb begin
    dtack_nxt = dtack_q;
    if (bus.ASn) begin
      dtack_nxt = 1'b1;
    end else if (cenb_q && !stall) begin
      dtack_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_CEN;
    end else begin
      phase <= phase_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      miss_q  <= '0;
      cs_l    <= 1'b0;
      cen_q   <= 1'b0;
      cenb_q  <= 1'b0;
      dtack_q <= 1'b1;
    end else begin
      acc     <= acc_nxt;
      miss_q  <= miss_nxt;
      cs_l    <= bus.bus_cs;
      cen_q   <= cen_nxt;
      cenb_q  <= cenb_nxt;
      dtack_q <= dtack_nxt;
    end
  end

  assign bus.cpu_cen  = cen_q;
  assign bus.cpu_cenb = cenb_q;
  assign bus.DTACKn   = dtack_q;
  assign bus.miss     = miss_q;

endmodule

// File: tb/tb_jtcop_dtack.sv
// Bench for jtcop_dtack: two instances (with and without tick recovery) share the same stimulus and
// are compared every clk against a reference model whose tick schedule comes from floor(n*num/den).
module tb_jtcop_dtack;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] num = '0;
  logic [W-1:0] den = 5'd1;
  logic         asn = 1'b1;
  logic         cs = 1'b0;
  logic         ok = 1'b0;
  logic         busy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtcop_dtack_if #(.W(W)) bi0 ();
  jtcop_dtack_if #(.W(W)) bi1 ();

  assign bi0.cen_num  = num;
  assign bi0.cen_den  = den;
  assign bi0.ASn      = asn;
  assign bi0.bus_cs   = cs;
  assign bi0.bus_ok   = ok;
  assign bi0.bus_busy = busy;
  assign bi1.cen_num  = num;
  assign bi1.cen_den  = den;
  assign bi1.ASn      = asn;
  assign bi1.bus_cs   = cs;
  assign bi1.bus_ok   = ok;
  assign bi1.bus_busy = busy;

  jtcop_dtack #(.W(W), .RECOVERY(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bi0));
  jtcop_dtack #(.W(W), .RECOVERY(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bi1));

  // reference model state, index = RECOVERY value
  int m_n;
  int m_csl;
  int m_cen[2];
  int m_cenb[2];
  int m_dtack[2];
  int m_miss[2];
  int m_next_cen[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tick_due(input int n, input int nm, input int dn);
    if (nm >= dn) return 1;
    return (((n * nm) / dn) != (((n - 1) * nm) / dn)) ? 1 : 0;
  endfunction

  task automatic model_update();
    int due, stall, rec, tick, nd;
    if (rst) begin
      m_n = 0;
      m_csl = 0;
      for (int r = 0; r < 2; r++) begin
        m_cen[r] = 0; m_cenb[r] = 0; m_dtack[r] = 1; m_miss[r] = 0; m_next_cen[r] = 1;
      end
      return;
    end
    m_n++;
    due   = tick_due(m_n, int'(num), int'(den));
    stall = (busy || (!asn && cs && !(ok && m_csl != 0))) ? 1 : 0;
    for (int r = 0; r < 2; r++) begin
      rec  = (r == 1 && !stall && !due && m_miss[r] > 0 && m_cen[r] == 0 && m_cenb[r] == 0) ? 1 : 0;
      tick = ((!stall && due) || rec) ? 1 : 0;
      nd   = asn ? 1 : ((m_cenb[r] == 1 && !stall) ? 0 : m_dtack[r]);
      if (r == 1 && stall && due && m_miss[r] < 31) m_miss[r]++;
      else if (rec) m_miss[r]--;
      m_dtack[r] = nd;
      m_cen[r]   = (tick && m_next_cen[r] == 1) ? 1 : 0;
      m_cenb[r]  = (tick && m_next_cen[r] == 0) ? 1 : 0;
      if (tick) m_next_cen[r] = 1 - m_next_cen[r];
    end
    m_csl = cs ? 1 : 0;
  endtask

  task automatic cycle_chk();
    logic c, cb, d;
    logic [W-1:0] m;
    for (int r = 0; r < 2; r++) begin
      c  = (r == 1) ? bi1.cpu_cen  : bi0.cpu_cen;
      cb = (r == 1) ? bi1.cpu_cenb : bi0.cpu_cenb;
      d  = (r == 1) ? bi1.DTACKn   : bi0.DTACKn;
      m  = (r == 1) ? bi1.miss     : bi0.miss;
      chk($sformatf("cen r%0d n%0d", r, m_n), 32'(c), 32'(m_cen[r]));
      chk($sformatf("cenb r%0d n%0d", r, m_n), 32'(cb), 32'(m_cenb[r]));
      chk($sformatf("dtack r%0d n%0d", r, m_n), 32'(d), 32'(m_dtack[r]));
      chk($sformatf("miss r%0d n%0d", r, m_n), 32'(m), 32'(m_miss[r]));
      chk($sformatf("both r%0d n%0d", r, m_n), 32'(c & cb), 32'd0);
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    cycle_chk();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    int dn, nm;

    // 1: 1/4 rate, idle bus
    num = 5'd1; den = 5'd4; asn = 1'b1; cs = 1'b0; ok = 1'b0; busy = 1'b0;
    do_reset();
    chk("reset cen", 32'(bi1.cpu_cen), 32'd0);
    chk("reset dtack", 32'(bi1.DTACKn), 32'd1);
    chk("reset miss", 32'(bi1.miss), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk($sformatf("t1 cen k%0d", k), 32'(bi1.cpu_cen), 32'((k % 8) == 4));
      chk($sformatf("t1 cenb k%0d", k), 32'(bi1.cpu_cenb), 32'((k % 8) == 0));
    end

    // 2: 3/4 rate gives 30 pulses in 40 clk
    num = 5'd3; den = 5'd4;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      pulses += int'(bi1.cpu_cen) + int'(bi1.cpu_cenb);
    end
    chk("t2 pulses", 32'(pulses), 32'd30);

    // 3: non-SDRAM access acknowledged at the first falling phase
    num = 5'd1; den = 5'd2; asn = 1'b0; cs = 1'b0;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        chk("t3 cenb", 32'(bi1.cpu_cenb), 32'd1);
        chk("t3 dtack pre", 32'(bi1.DTACKn), 32'd1);
      end
    end
    chk("t3 dtack low", 32'(bi1.DTACKn), 32'd0);
    asn = 1'b1;
    step();
    chk("t3 dtack rel", 32'(bi1.DTACKn), 32'd1);

    // 4: bus_ok already high when cs rises is ignored for one clk
    num = 5'd1; den = 5'd1; asn = 1'b0; cs = 1'b1; ok = 1'b1;
    do_reset();
    step();
    chk("t4 no cen", 32'(bi1.cpu_cen), 32'd0);
    chk("t4 miss", 32'(bi1.miss), 32'd1);
    for (int k = 0; k < 4; k++) step();
    chk("t4 dtack", 32'(bi1.DTACKn), 32'd0);

    // 5a: 1/2 rate, 20 clk stall accrues 10 missed ticks
    num = 5'd1; den = 5'd2; asn = 1'b0; cs = 1'b1; ok = 1'b0;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      pulses += int'(bi1.cpu_cen) + int'(bi1.cpu_cenb);
    end
    chk("t5 no pulses", 32'(pulses), 32'd0);
    chk("t5 miss", 32'(bi1.miss), 32'd10);
    chk("t5 miss norec", 32'(bi0.miss), 32'd0);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("t5 dtack", 32'(bi1.DTACKn), 32'd0);

    // 5b: 1/3 rate leaves idle clks so the debt drains
    num = 5'd1; den = 5'd3; ok = 1'b0; asn = 1'b1;
    do_reset();
    asn = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("t5b miss", 32'(bi1.miss), 32'd6);
    ok = 1'b1;
    for (int k = 0; k < 40; k++) step();
    chk("t5b drained", 32'(bi1.miss), 32'd0);

    // 6: reset in the middle of a stall, then a bus_busy-only stall
    num = 5'd1; den = 5'd2; asn = 1'b0; cs = 1'b1; ok = 1'b0;
    do_reset();
    for (int k = 0; k < 14; k++) step();
    chk("t6 miss7", 32'(bi1.miss), 32'd7);
    do_reset();
    chk("t6 rst cen", 32'(bi1.cpu_cen), 32'd0);
    chk("t6 rst cenb", 32'(bi1.cpu_cenb), 32'd0);
    chk("t6 rst dtack", 32'(bi1.DTACKn), 32'd1);
    chk("t6 rst miss", 32'(bi1.miss), 32'd0);
    asn = 1'b1; cs = 1'b0; busy = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      pulses += int'(bi1.cpu_cen) + int'(bi1.cpu_cenb);
    end
    chk("t6 busy pulses", 32'(pulses), 32'd0);
    chk("t6 busy miss", 32'(bi1.miss), 32'd5);
    busy = 1'b0;

    // randomized segments against the model
    for (int seg = 0; seg < 10; seg++) begin
      dn = int'($urandom_range(1, 31));
      nm = int'($urandom_range(0, (dn + 2 > 31) ? 31 : dn + 2));
      den = W'(dn); num = W'(nm);
      asn = 1'b1; cs = 1'b0; ok = 1'b0; busy = 1'b0;
      do_reset();
      for (int k = 0; k < 150; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          asn = ~asn;
          if (!asn) cs = ($urandom_range(0, 3) != 0);
        end
        ok   = ($urandom_range(0, 3) == 0);
        busy = ($urandom_range(0, 15) == 0);
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
